// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin grant sequencer for a shared 16-way resource with ready/done handshake and hold watchdog.
// Define ARB_LOCK_EN to add the lock input, which re-grants the owner directly after done.
module rr_arbiter16 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    input  logic        res_ready,
    input  logic        res_done,
`ifdef ARB_LOCK_EN
    input  logic        lock,
`endif
    output logic        grant_valid,
    output logic [3:0]  grant_sel,
    output logic [15:0] grant_onehot,
    output logic        busy,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;
    state_t      r_state, w_state_nx;
    logic [3:0]  r_ptr, w_ptr_nx, r_sel, w_sel_nx, w_win;
    logic [7:0]  r_cnt, w_cnt_nx;
    logic        r_to, w_to_nx, w_any, w_own, w_lock;
    logic [15:0] w_slot;
    always_comb begin
        for (int k = 0; k < 16; k++) w_slot[k] = req[15-k];
    end
    // Scan downward so the slot closest to ptr is written last and wins.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (w_slot[r_ptr + 4'(i)]) begin
                w_win = r_ptr + 4'(i);
                w_any = 1'b1;
            end
        end
    end
    assign w_own = w_slot[r_sel];
`ifdef ARB_LOCK_EN
    assign w_lock = lock & w_own;
`else
    assign w_lock = 1'b0;
`endif
    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_sel_nx   = r_sel;
        w_cnt_nx   = r_cnt;
        w_to_nx    = 1'b0;
        case (r_state)
            IDLE: if (w_any) begin
                w_state_nx = REQ;
                w_sel_nx   = w_win;
            end
            REQ: if (res_ready) begin
                w_state_nx = BUSY;
                w_cnt_nx   = '0;
            end else if (!w_own) begin
                w_state_nx = IDLE;
                w_ptr_nx   = r_sel + 4'd1;
            end
            BUSY: if (res_done) begin
                w_state_nx = w_lock ? REQ : IDLE;
                w_ptr_nx   = w_lock ? r_ptr : r_sel + 4'd1;
            end else if (r_cnt + 8'd1 == 8'(MAX_HOLD)) begin
                w_state_nx = IDLE;
                w_ptr_nx   = r_sel + 4'd1;
                w_to_nx    = 1'b1;
            end else begin
                w_cnt_nx   = r_cnt + 8'd1;
            end
            default: w_state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_sel   <= w_sel_nx;
            r_cnt   <= w_cnt_nx;
            r_to    <= w_to_nx;
        end
    end
    assign grant_valid  = r_state == REQ;
    assign busy         = r_state == BUSY;
    assign grant_sel    = r_sel;
    assign grant_onehot = (r_state != IDLE) ? 16'h8000 >> r_sel : 16'h0000;
    assign timeout      = r_to;
endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed vector table plus hand sequences for rotation, wrap, reset and lock.
module tb_rr_arbiter16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] req = '0;
    logic        res_ready = 1'b0;
    logic        res_done = 1'b0;
    logic        grant_valid, busy, timeout;
    logic [3:0]  grant_sel;
    logic [15:0] grant_onehot;
    int          checks = 0;
    int          errors = 0;
`ifdef ARB_LOCK_EN
    logic        lock = 1'b0;
`endif
    rr_arbiter16 #(.MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req(req), .res_ready(res_ready), .res_done(res_done),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .grant_valid(grant_valid), .grant_sel(grant_sel), .grant_onehot(grant_onehot),
        .busy(busy), .timeout(timeout)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [15:0] req;
        logic        rdy, done, v;
        logic [3:0]  sel;
        logic [15:0] oh;
        logic        b, t;
    } vec_t;
    vec_t tbl[27];
    task automatic cyc(input logic [15:0] r, input logic rd, input logic dn);
        req = r;
        res_ready = rd;
        res_done = dn;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic v, input logic [3:0] sel, input logic [15:0] oh, input logic b, input logic t);
        checks++;
        if ({grant_valid, grant_sel, grant_onehot, busy, timeout} !== {v, sel, oh, b, t}) begin
            errors++;
            $display("FAIL %s actual v=%b sel=%0d oh=%h busy=%b to=%b required v=%b sel=%0d oh=%h busy=%b to=%b",
                     nm, grant_valid, grant_sel, grant_onehot, busy, timeout, v, sel, oh, b, t);
        end
    endtask
    initial begin
        tbl[0]  = '{16'h8000, 1'b0, 1'b0, 1'b1, 4'd0, 16'h8000, 1'b0, 1'b0};
        tbl[1]  = '{16'h8000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h8000, 1'b1, 1'b0};
        tbl[2]  = '{16'h8000, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{16'hC000, 1'b0, 1'b0, 1'b1, 4'd1, 16'h4000, 1'b0, 1'b0};
        tbl[4]  = '{16'hC000, 1'b1, 1'b0, 1'b0, 4'd1, 16'h4000, 1'b1, 1'b0};
        tbl[5]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'd1, 16'h0000, 1'b0, 1'b0};
        tbl[6]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'd1, 16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{16'h1000, 1'b0, 1'b0, 1'b1, 4'd3, 16'h1000, 1'b0, 1'b0};
        tbl[8]  = '{16'h9000, 1'b0, 1'b0, 1'b1, 4'd3, 16'h1000, 1'b0, 1'b0};
        tbl[9]  = '{16'h8000, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0000, 1'b0, 1'b0};
        tbl[10] = '{16'h8800, 1'b0, 1'b0, 1'b1, 4'd4, 16'h0800, 1'b0, 1'b0};
        tbl[11] = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd4, 16'h0800, 1'b1, 1'b0};
        tbl[12] = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd4, 16'h0800, 1'b1, 1'b0};
        tbl[13] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'd4, 16'h0000, 1'b0, 1'b0};
        tbl[14] = '{16'h0400, 1'b0, 1'b0, 1'b1, 4'd5, 16'h0400, 1'b0, 1'b0};
        tbl[15] = '{16'h0400, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0400, 1'b1, 1'b0};
        tbl[16] = '{16'h0400, 1'b0, 1'b0, 1'b0, 4'd5, 16'h0400, 1'b1, 1'b0};
        tbl[17] = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'd5, 16'h0400, 1'b1, 1'b0};
        tbl[18] = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'd5, 16'h0400, 1'b1, 1'b0};
        tbl[19] = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'd5, 16'h0000, 1'b0, 1'b1};
        tbl[20] = '{16'h0000, 1'b0, 1'b0, 1'b0, 4'd5, 16'h0000, 1'b0, 1'b0};
        tbl[21] = '{16'h0600, 1'b0, 1'b0, 1'b1, 4'd6, 16'h0200, 1'b0, 1'b0};
        tbl[22] = '{16'h0600, 1'b1, 1'b1, 1'b0, 4'd6, 16'h0200, 1'b1, 1'b0};
        tbl[23] = '{16'h0600, 1'b0, 1'b0, 1'b0, 4'd6, 16'h0200, 1'b1, 1'b0};
        tbl[24] = '{16'h0600, 1'b0, 1'b0, 1'b0, 4'd6, 16'h0200, 1'b1, 1'b0};
        tbl[25] = '{16'h0600, 1'b0, 1'b0, 1'b0, 4'd6, 16'h0200, 1'b1, 1'b0};
        tbl[26] = '{16'h0000, 1'b0, 1'b1, 1'b0, 4'd6, 16'h0000, 1'b0, 1'b0};
        cyc(16'hFFFF, 1'b1, 1'b1);
        cyc(16'hFFFF, 1'b1, 1'b1);
        chk("reset", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 27; i++) begin
            cyc(tbl[i].req, tbl[i].rdy, tbl[i].done);
            chk($sformatf("vec%0d", i), tbl[i].v, tbl[i].sel, tbl[i].oh, tbl[i].b, tbl[i].t);
        end
        reset = 1'b1;
        cyc(16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        for (int t = 0; t < 15; t++) begin
            cyc(16'hFFFF, 1'b1, 1'b1);
            chk($sformatf("rot_req%0d", t), 1'b1, 4'(t), 16'h8000 >> t, 1'b0, 1'b0);
            cyc(16'hFFFF, 1'b1, 1'b1);
            chk($sformatf("rot_busy%0d", t), 1'b0, 4'(t), 16'h8000 >> t, 1'b1, 1'b0);
            cyc(16'hFFFF, 1'b1, 1'b1);
            chk($sformatf("rot_idle%0d", t), 1'b0, 4'(t), 16'h0000, 1'b0, 1'b0);
        end
        cyc(16'h8001, 1'b0, 1'b0);
        chk("wrap_req15", 1'b1, 4'd15, 16'h0001, 1'b0, 1'b0);
        cyc(16'h8001, 1'b1, 1'b0);
        chk("wrap_busy15", 1'b0, 4'd15, 16'h0001, 1'b1, 1'b0);
        cyc(16'h8001, 1'b0, 1'b1);
        chk("wrap_idle", 1'b0, 4'd15, 16'h0000, 1'b0, 1'b0);
        cyc(16'h8001, 1'b0, 1'b0);
        chk("wrap_req0", 1'b1, 4'd0, 16'h8000, 1'b0, 1'b0);
        cyc(16'h0001, 1'b0, 1'b0);
        chk("withdraw0", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        cyc(16'h0001, 1'b0, 1'b0);
        chk("req15_again", 1'b1, 4'd15, 16'h0001, 1'b0, 1'b0);
        cyc(16'h0001, 1'b1, 1'b0);
        chk("busy15_again", 1'b0, 4'd15, 16'h0001, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(16'h0001, 1'b0, 1'b1);
        chk("reset_in_busy", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(16'h8001, 1'b0, 1'b0);
        chk("after_reset_ptr0", 1'b1, 4'd0, 16'h8000, 1'b0, 1'b0);
`ifdef ARB_LOCK_EN
        reset = 1'b1;
        cyc(16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        lock = 1'b1;
        cyc(16'hC000, 1'b0, 1'b0);
        chk("lock_req0", 1'b1, 4'd0, 16'h8000, 1'b0, 1'b0);
        cyc(16'hC000, 1'b1, 1'b0);
        chk("lock_busy0", 1'b0, 4'd0, 16'h8000, 1'b1, 1'b0);
        cyc(16'hC000, 1'b0, 1'b1);
        chk("lock_regrant0", 1'b1, 4'd0, 16'h8000, 1'b0, 1'b0);
        cyc(16'hC000, 1'b1, 1'b0);
        chk("lock_busy0b", 1'b0, 4'd0, 16'h8000, 1'b1, 1'b0);
        lock = 1'b0;
        cyc(16'hC000, 1'b0, 1'b1);
        chk("unlock_idle", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        cyc(16'hC000, 1'b0, 1'b0);
        chk("unlock_req1", 1'b1, 4'd1, 16'h4000, 1'b0, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Round-robin arbiter/sequencer for one shared 16-way resource. Its 4-bit grant index drives the select of a mux16_single_input.
- Picks one of 16 requesters and holds the grant through a ready/done handshake with the shared resource.
- A watchdog forces release if the resource never signals completion.
- Sits between 16 requesting units and one shared single-bit-per-requester mux path.

Parameters:
- MAX_HOLD, 15: max cycles in BUSY before forced release. Range 1..255; 8-bit counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  16  request vector. Slot k (0..15) is req[15-k], matching mux16 select order (select 0 picks bit 15).
- res_ready  in  1  resource accepts grant this cycle.
- res_done  in  1  resource finished the current transaction. Single-cycle pulse.
- grant_valid  out  1  grant offered to the resource; high only in REQ.
- grant_sel  out  4  winning slot index; drives the mux16 select.
- grant_onehot  out  16  bit (15-grant_sel) set in REQ and BUSY; else 0.
- busy  out  1  high in BUSY.
- timeout  out  1  one-cycle pulse on watchdog release.

Behaviour:
- All state updates on rising clk. Reset is synchronous and dominates every other input, including mid-transaction.
- Reset values: state IDLE, ptr 0, grant_sel 0, grant_valid 0, grant_onehot 0, busy 0, timeout 0, hold counter 0.
- Priority: search slots ptr, ptr+1, ... wrapping mod 16. The first slot with its request bit high wins.
- IDLE:
  - If req != 0, latch the winner into grant_sel and go to REQ.
  - grant_valid rises one cycle after req is sampled: latency 1.
  - req == 0: stay in IDLE, outputs 0.
- REQ:
  - grant_valid=1; grant_sel stays stable.
  - res_ready=1: go to BUSY and clear the counter. The grant is consumed the same cycle.
  - Owner's req bit low and res_ready=0: withdraw to IDLE, ptr=grant_sel+1.
  - Owner's req bit low and res_ready=1 in the same cycle: ready wins, go to BUSY.
  - Other requesters' bits are ignored.
- BUSY:
  - busy=1, grant_valid=0. Counter increments each cycle.
  - res_done=1: go to IDLE, ptr=grant_sel+1 (4-bit wrap, 15 goes to 0).
  - Counter reaches MAX_HOLD with no done: go to IDLE, ptr=grant_sel+1, timeout=1 for exactly one cycle.
  - done on the same cycle as the limit: treated as done, no timeout.
  - Owner's req bit is ignored in BUSY.
- res_done outside BUSY and res_ready outside REQ are ignored.
- Back-to-back: IDLE always costs one cycle between transactions.
- grant_sel holds its last value in IDLE; consumers qualify it with grant_valid or busy.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - If lock=1 and the owner's req bit is still high on the res_done cycle, go directly to REQ with the same grant_sel. ptr is not advanced.
  - Timeout always releases and advances ptr, regardless of lock.
- When undefined: no lock port; behaviour exactly as above.

Test Plan:
- Reset, then req=16'h8000 (slot 0) -> next cycle grant_valid=1, grant_sel=0, grant_onehot=16'h8000. After res_ready=1 then res_done=1 -> IDLE, ptr=1.
- req=16'hFFFF held, res_ready=1 and res_done one cycle after grant -> grant_sel sequence 0,1,...,15,0. Each transaction is 3 cycles (REQ, BUSY, IDLE).
- Wrap: ptr=15 with req=16'h8001 -> grant_sel=15 (req[0]). Next arbitration grants slot 0 (req[15]).
- MAX_HOLD=4, grant accepted, res_done never asserted -> busy for 4 cycles, timeout pulses 1 cycle, state IDLE, ptr advanced.
- In REQ with grant_sel=3, drop req[12] with res_ready=0 -> IDLE next cycle, grant_valid=0, ptr=4. Separately, reset asserted during BUSY -> all outputs 0 on the next cycle.
- ARB_LOCK_EN: req=16'hC000 with lock=1 on slot 0 -> slot 0 re-granted on consecutive transactions. Drop lock -> slot 1 granted next.
